// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the implied-UC collector:
//   LIT_IDX_MAX  largest literal index (overridable with a define)
//   LIT_W        signed literal width, MSB carries polarity
//   lit_t        signed literal type
//   MODE_MASK / MODE_PQ  input_mode encodings
// -----------------------------------------------------------------------------
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

package uc_pkg;

    localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;

    typedef logic signed [LIT_W-1:0] lit_t;

    localparam logic MODE_MASK = 1'b0;
    localparam logic MODE_PQ   = 1'b1;

endpackage

// File: rtl/uc_imp_fifo.sv
// -----------------------------------------------------------------------------
// uc_imp_fifo
// Single-clock implication FIFO with a zero-latency head.
//   clk, rst_n  clock, async active-low reset
//   flush       synchronous clear, wins over push/pop
//   push, din   write strobe and literal
//   pop         consume head (ignored when empty)
//   head        current head literal
//   full, empty derived from the occupancy count
// A push while full is taken only if a pop frees the slot in the same cycle.
// -----------------------------------------------------------------------------
module uc_imp_fifo #(
    parameter int DEPTH = 8,
    parameter int LIT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [LIT_W-1:0] din,
    input  logic             pop,
    output logic [LIT_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uc_imp_collector.sv
// -----------------------------------------------------------------------------
// uc_imp_collector
// Gathers implied unit clauses from every BCP engine into per-engine FIFOs and
// presents one head literal per cycle to the UC arbiter.
//   clk, rst_n       clock, async active-low reset
//   flush            clears all FIFOs and the round-robin pointer
//   eng_imp_valid    per-engine push strobe
//   eng_imp_lit      per-engine literal, lane i at [i*LIT_W +: LIT_W]
//   eng2uca_full     per-FIFO full flag
//   input_mode       MODE_MASK: engmask/uca_rd select and pop
//                    MODE_PQ:   round-robin grant over non-empty FIFOs
//   engmask, uca_rd  one-hot FIFO select and read strobe (mask mode)
//   eng2uca          selected head literal (0 when nothing is selectable)
//   eng2uca_valid    eng2uca is consumed this cycle
//   eng2uca_empty    selected FIFO empty (mask) / all FIFOs empty (PQ)
//   overflow         sticky: some push was dropped
// -----------------------------------------------------------------------------
module uc_imp_collector
    import uc_pkg::*;
#(
    parameter int NUM_ENGINE = 4,
    parameter int DEPTH      = 8,
    parameter int LIT_W      = uc_pkg::LIT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_ENGINE-1:0]       eng_imp_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng_imp_lit,
    output logic [NUM_ENGINE-1:0]       eng2uca_full,
    input  logic                        input_mode,
    input  logic [NUM_ENGINE-1:0]       engmask,
    input  logic                        uca_rd,
    output logic [LIT_W-1:0]            eng2uca,
    output logic                        eng2uca_valid,
    output logic                        eng2uca_empty,
    output logic                        overflow
);

    localparam int RW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    logic [LIT_W-1:0]      head [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] fifo_empty;
    logic [NUM_ENGINE-1:0] pop_vec;
    logic [RW-1:0]         rr_ptr;

    logic                  mask_ok;
    logic [RW-1:0]         mask_idx;
    logic                  pq_hit;
    logic [RW-1:0]         pq_idx;
    logic                  sel_hit;
    logic [RW-1:0]         sel_idx;
    logic                  take;

    for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_fifo
        uc_imp_fifo #(
            .DEPTH (DEPTH),
            .LIT_W (LIT_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (eng_imp_valid[g]),
            .din   (eng_imp_lit[g*LIT_W +: LIT_W]),
            .pop   (pop_vec[g]),
            .head  (head[g]),
            .full  (eng2uca_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // Mask mode: only a strictly one-hot engmask selects a FIFO.
    always_comb begin
        mask_ok  = $onehot(engmask);
        mask_idx = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (engmask[i]) mask_idx = RW'(i);
        end
    end

    // PQ mode: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        int            idx;
        logic [RW-1:0] cand;
        idx    = 0;
        cand   = '0;
        pq_hit = 1'b0;
        pq_idx = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_ENGINE) idx = idx - NUM_ENGINE;
            cand = RW'(idx);
            if (!pq_hit && !fifo_empty[cand]) begin
                pq_hit = 1'b1;
                pq_idx = cand;
            end
        end
    end

    always_comb begin
        sel_hit       = 1'b0;
        sel_idx       = '0;
        take          = 1'b0;
        eng2uca_empty = 1'b1;
        if (input_mode == MODE_PQ) begin
            sel_hit       = pq_hit;
            sel_idx       = pq_idx;
            take          = pq_hit;
            eng2uca_empty = &fifo_empty;
        end else begin
            sel_idx       = mask_idx;
            sel_hit       = mask_ok & ~fifo_empty[mask_idx];
            take          = sel_hit & uca_rd;
            eng2uca_empty = mask_ok ? fifo_empty[mask_idx] : 1'b1;
        end
        // flush cancels the pop, so nothing is handed over that cycle
        take          = take & ~flush;
        eng2uca       = sel_hit ? head[sel_idx] : '0;
        eng2uca_valid = take;
        pop_vec       = '0;
        if (take) pop_vec[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if ((input_mode == MODE_PQ) && pq_hit) begin
            rr_ptr <= (pq_idx == RW'(NUM_ENGINE - 1)) ? '0 : pq_idx + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!flush && |(eng_imp_valid & eng2uca_full & ~pop_vec)) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uc_imp_collector.sv
module tb_uc_imp_collector;

    localparam int N  = 4;
    localparam int LW = uc_pkg::LIT_W;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    eng_imp_valid;
    logic [N*LW-1:0] eng_imp_lit;
    logic [N-1:0]    eng2uca_full;
    logic            input_mode;
    logic [N-1:0]    engmask;
    logic            uca_rd;
    logic [LW-1:0]   eng2uca;
    logic            eng2uca_valid;
    logic            eng2uca_empty;
    logic            overflow;

    uc_imp_collector #(.NUM_ENGINE(N), .DEPTH(8), .LIT_W(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .eng_imp_valid (eng_imp_valid),
        .eng_imp_lit   (eng_imp_lit),
        .eng2uca_full  (eng2uca_full),
        .input_mode    (input_mode),
        .engmask       (engmask),
        .uca_rd        (uca_rd),
        .eng2uca       (eng2uca),
        .eng2uca_valid (eng2uca_valid),
        .eng2uca_empty (eng2uca_empty),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            fl;
        logic [N-1:0]    vld;
        logic [N*LW-1:0] lits;
        logic            mode;
        logic [N-1:0]    em;
        logic            rd;
        logic [LW-1:0]   x_lit;
        logic            x_vld;
        logic            x_emp;
        logic [N-1:0]    x_full;
        logic            x_ovf;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [N*LW-1:0] ln(input int a, input int b, input int c, input int d);
        return {LW'(d), LW'(c), LW'(b), LW'(a)};
    endfunction

    task automatic add(input logic fl, input logic [N-1:0] vld, input logic [N*LW-1:0] lits,
                       input logic mode, input logic [N-1:0] em, input logic rd,
                       input int xl, input logic xv, input logic xe,
                       input logic [N-1:0] xf, input logic xo);
        vec_t v;
        v.fl = fl; v.vld = vld; v.lits = lits; v.mode = mode; v.em = em; v.rd = rd;
        v.x_lit = LW'(xl); v.x_vld = xv; v.x_emp = xe; v.x_full = xf; v.x_ovf = xo;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush         = v.fl;
        eng_imp_valid = v.vld;
        eng_imp_lit   = v.lits;
        input_mode    = v.mode;
        engmask       = v.em;
        uca_rd        = v.rd;
    endtask

    task automatic idle_inputs();
        flush = 0; eng_imp_valid = '0; eng_imp_lit = '0;
        input_mode = 0; engmask = '0; uca_rd = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // reset / idle
        add(0, 4'b0000, '0, 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 0);
        // mask mode: +5 then -3 into engine 2, no same-cycle bypass
        add(0, 4'b0100, ln(0,0,5,0),  0, 4'b0100, 0,   0, 0, 1, 4'b0000, 0);
        add(0, 4'b0100, ln(0,0,-3,0), 0, 4'b0100, 0,   5, 0, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 0, 4'b0100, 1,   5, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 0, 4'b0100, 1,  -3, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 0, 4'b0100, 1,   0, 0, 1, 4'b0000, 0);
        // PQ mode: +1,+2,+4 in FIFOs 0,1,3; engmask/uca_rd ignored
        add(0, 4'b1011, ln(1,2,0,4), 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0100, 0,   1, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0000, 1,   2, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   4, 1, 0, 4'b0000, 0);
        add(0, 4'b1010, ln(0,7,0,9), 1, 4'b0000, 0,   0, 0, 1, 4'b0000, 0);
        // rr_ptr back at 0: FIFO 1 first, then 3 (skipping empty 2)
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   7, 1, 0, 4'b0000, 0);
        add(0, 4'b0101, ln(3,0,6,0), 1, 4'b0000, 0,   9, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   3, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   6, 1, 0, 4'b0000, 0);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   0, 0, 1, 4'b0000, 0);
        // full boundary on FIFO 1
        for (int k = 0; k < 8; k++)
            add(0, 4'b0010, ln(0,10+k,0,0), 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 0);
        add(0, 4'b0010, ln(0,18,0,0), 0, 4'b0010, 1,  10, 1, 0, 4'b0010, 0);
        add(0, 4'b0000, '0, 0, 4'b0010, 0,  11, 0, 0, 4'b0010, 0);
        add(0, 4'b0010, ln(0,99,0,0), 0, 4'b0000, 0,   0, 0, 1, 4'b0010, 0);
        add(0, 4'b0000, '0, 0, 4'b0010, 1,  11, 1, 0, 4'b0010, 1);
        for (int k = 12; k <= 18; k++)
            add(0, 4'b0000, '0, 0, 4'b0010, 1,   k, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0010, 1,   0, 0, 1, 4'b0000, 1);
        // flush with a simultaneous push; overflow kept
        add(0, 4'b0101, ln(5,0,6,0), 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);
        add(1, 4'b0001, ln(7,0,0,0), 0, 4'b0001, 0,   5, 0, 0, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0001, 0,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0100, 0,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);
        // bad mask: no selection, no pop
        add(0, 4'b0110, ln(0,21,22,0), 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0110, 1,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0010, 0,  21, 0, 0, 4'b0000, 1);
        add(0, 4'b0000, '0, 0, 4'b0100, 1,  22, 1, 0, 4'b0000, 1);
        // flush clears rr_ptr: rr=2 after this grant, flush, then FIFO 1 wins over 3
        add(0, 4'b0000, '0, 1, 4'b0000, 0,  21, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, '0, 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b1010, ln(0,31,0,33), 0, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,  31, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,  33, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, '0, 1, 4'b0000, 0,   0, 0, 1, 4'b0000, 1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            n_vec++;
            chk("valid", i, 64'(eng2uca_valid), 64'(vq[i].x_vld));
            chk("empty", i, 64'(eng2uca_empty), 64'(vq[i].x_emp));
            chk("full",  i, 64'(eng2uca_full),  64'(vq[i].x_full));
            chk("ovf",   i, 64'(overflow),      64'(vq[i].x_ovf));
            // head value is only defined when something is selectable, or 0 for no selection
            if (!vq[i].x_emp || (vq[i].mode == 1'b0 && !$onehot(vq[i].em)))
                chk("lit", i, 64'(eng2uca), 64'(vq[i].x_lit));
            @(posedge clk);
            #1;
        end

        // async reset mid-stream: fill FIFO 3, hold a PQ grant, then drop rst_n between edges
        idle_inputs();
        for (int k = 0; k < 9; k++) begin
            eng_imp_valid = 4'b1000;
            eng_imp_lit   = ln(0, 0, 0, 50 + k);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        input_mode = 1'b1;
        #1;
        n_vec++;
        chk("pre_rst_full",  100, 64'(eng2uca_full),  64'(4'b1000));
        chk("pre_rst_valid", 100, 64'(eng2uca_valid), 64'(1));
        chk("pre_rst_lit",   100, 64'(eng2uca),       64'(LW'(50)));
        chk("pre_rst_ovf",   100, 64'(overflow),      64'(1));
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_full",  101, 64'(eng2uca_full),  64'(4'b0000));
        chk("rst_valid", 101, 64'(eng2uca_valid), 64'(0));
        chk("rst_empty", 101, 64'(eng2uca_empty), 64'(1));
        chk("rst_lit",   101, 64'(eng2uca),       64'(0));
        chk("rst_ovf",   101, 64'(overflow),      64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        chk("post_rst_empty", 102, 64'(eng2uca_empty), 64'(1));
        chk("post_rst_valid", 102, 64'(eng2uca_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
